// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: sits between the core's data port and the data SRAM.
// Accesses to 0xF000-0xFFFF are served locally: a byte TX FIFO feeding an
// 8N1 transmitter, a status register, a baud divisor and a cycle counter.
// Everything else passes straight through to the SRAM.
// Optional feature: define MMIO_CYCLE_CNT_EN to build the CYCLE counter;
// without it CYCLE reads 0 and ignores writes.
module mmio_uart_bridge #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dm_addr,
  input  logic [3:0]  dm_w_en,
  input  logic [31:0] dm_write_data,
  output logic [31:0] dm_read_data,
  input  logic        halt,
  output logic [15:0] sram_addr,
  output logic [3:0]  sram_w_en,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Decode and strobes
  logic        mmio_s;
  logic [1:0]  reg_idx_s;
  logic        push_req_s;
  logic        ovf_clr_s;
  logic        div_wr_s;
  logic        addr_unused_s;

  // FIFO
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] wr_ptr_nxt_s;
  logic [AW:0] rd_ptr_nxt_s;
  logic [7:0]  fifo_mem_r [FIFO_DEPTH];
  logic [7:0]  head_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        push_ok_s;
  logic        pop_s;
  logic        ovf_set_s;
  logic        ovf_r;

  // Baud divisor and transmitter
  logic [15:0] div_r;
  tx_state_t   state_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic [15:0] cnt_r;
  logic        bit_end_s;
  logic        frame_end_s;
  logic        tx_r;
  logic        busy_r;
  logic        busy_nxt_s;

  // Register read path
  logic [31:0] cycle_s;
  logic [31:0] reg_val_s;

  // Window decode and per-register write strobes for the current access.
  always_comb begin
    mmio_s        = (dm_addr[15:12] == 4'hF);
    reg_idx_s     = dm_addr[3:2];
    push_req_s    = mmio_s && (reg_idx_s == 2'd0) && dm_w_en[0];
    ovf_clr_s     = mmio_s && (reg_idx_s == 2'd1) && dm_w_en[0] && dm_write_data[0];
    div_wr_s      = mmio_s && (reg_idx_s == 2'd3) && (dm_w_en[1:0] == 2'b11);
    addr_unused_s = ^{dm_addr[11:4], dm_addr[1:0]};
  end

  // FIFO status, push/pop arbitration and next-cycle busy flag.
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    head_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
    bit_end_s    = (cnt_r == 16'd1);
    frame_end_s  = (state_r == ST_STOP) && bit_end_s;
    // The transmitter takes a new byte when idle, or straight out of the
    // last stop-bit cycle so queued frames run back to back.
    pop_s        = !fifo_empty_s && ((state_r == ST_IDLE) || frame_end_s);
    // A push into a full FIFO still fits if a pop frees a slot at the same edge.
    push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
    ovf_set_s    = push_req_s && fifo_full_s && !pop_s;
    wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    busy_nxt_s   = pop_s ||
                   ((state_r != ST_IDLE) && !frame_end_s) ||
                   (wr_ptr_nxt_s != rd_ptr_nxt_s);
  end

  // FIFO pointers, sticky overflow flag and baud divisor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      ovf_r    <= 1'b0;
      div_r    <= DEFAULT_DIV;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (div_wr_s) begin
        div_r <= (dm_write_data[15:0] == 16'd0) ? 16'd1 : dm_write_data[15:0];
      end else begin
        div_r <= div_r;
      end
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= dm_write_data[7:0];
    end
  end

  // 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, div cycles each.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      cnt_r     <= 16'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r <= head_s;
            cnt_r   <= div_r;
            tx_r    <= 1'b0;
            state_r <= ST_START;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            cnt_r     <= div_r;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= ST_DATA;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            cnt_r <= div_r;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              shift_r <= head_s;
              cnt_r   <= div_r;
              tx_r    <= 1'b0;
              state_r <= ST_START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_r;
  logic        cyc_wr_s;

  // CYCLE write strobe: only a full-word store replaces the counter.
  always_comb begin
    cyc_wr_s = mmio_s && (reg_idx_s == 2'd2) && (dm_w_en == 4'b1111);
  end

  // Free-running cycle counter, frozen while the core is halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r <= 32'h0000_0000;
    end else if (cyc_wr_s) begin
      cycle_r <= dm_write_data;
    end else if (!halt) begin
      cycle_r <= cycle_r + 32'd1;
    end else begin
      cycle_r <= cycle_r;
    end
  end

  assign cycle_s = cycle_r;
`else
  logic cyc_unused_s;

  assign cycle_s      = 32'h0000_0000;
  assign cyc_unused_s = ^{halt, dm_write_data[31:16]};
`endif

  // Load data: local register inside the window, SRAM data elsewhere.
  always_comb begin
    reg_val_s = 32'h0000_0000;
    case (reg_idx_s)
      2'd0:    reg_val_s = 32'h0000_0000;
      2'd1:    reg_val_s = {28'h000_0000, busy_r, fifo_full_s, fifo_empty_s, ovf_r};
      2'd2:    reg_val_s = cycle_s;
      2'd3:    reg_val_s = {16'h0000, div_r};
      default: reg_val_s = 32'h0000_0000;
    endcase
    dm_read_data = mmio_s ? reg_val_s : sram_read_data;
  end

  assign sram_addr       = dm_addr;
  assign sram_w_en       = mmio_s ? 4'b0000 : dm_w_en;
  assign sram_write_data = dm_write_data;
  assign tx              = tx_r;
  assign tx_busy         = busy_r;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: register table plus serial-frame,
// overflow, cycle-counter and mid-frame-reset sequences.
module tb_mmio_uart_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dm_addr;
  logic [3:0]  dm_w_en;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        halt;
  logic [15:0] sram_addr;
  logic [3:0]  sram_w_en;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        tx;
  logic        tx_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_uart_bridge #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst(rst),
    .dm_addr(dm_addr), .dm_w_en(dm_w_en), .dm_write_data(dm_write_data),
    .dm_read_data(dm_read_data), .halt(halt),
    .sram_addr(sram_addr), .sram_w_en(sram_w_en), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .tx(tx), .tx_busy(tx_busy)
  );

  // Small word-addressed SRAM model with byte lanes.
  logic [31:0] sram_mem [0:255];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (sram_w_en[b]) sram_mem[sram_addr[9:2]][b*8 +: 8] <= sram_write_data[b*8 +: 8];
    end
  end
  assign sram_read_data = sram_mem[sram_addr[9:2]];

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_swen;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    dm_addr       = a;
    dm_w_en       = w;
    dm_write_data = d;
  endtask

  // Finish the current cycle and return to an idle bus just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    drive(16'h0000, 4'b0000, 32'h0000_0000);
  endtask

  task automatic do_reset();
    drive(16'h0000, 4'b0000, 32'h0000_0000);
    halt = 1'b0;
    rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] data;
    logic       exp_bit;
    int         bi;

    //                addr      wen      wdata          chk   exp_rd         swen
    vecs[0]  = '{16'hF004, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0002, 4'b0000};
    vecs[1]  = '{16'hF00C, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_01B2, 4'b0000};
    vecs[2]  = '{16'h0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4'b1111};
    vecs[3]  = '{16'h0100, 4'b0000, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 4'b0000};
    vecs[4]  = '{16'h0000, 4'b1111, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 4'b1111};
    vecs[5]  = '{16'hF000, 4'b1111, 32'h0000_F000, 1'b1, 32'h0000_0000, 4'b0000};
    vecs[6]  = '{16'hF004, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0008, 4'b0000};
    vecs[7]  = '{16'h0000, 4'b0000, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0000};
    vecs[8]  = '{16'hF004, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_000A, 4'b0000};
    vecs[9]  = '{16'hF00C, 4'b0011, 32'h0000_0000, 1'b1, 32'h0000_01B2, 4'b0000};
    vecs[10] = '{16'hF7FC, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 4'b0000};
    vecs[11] = '{16'hF00C, 4'b0001, 32'h0000_0005, 1'b1, 32'h0000_0001, 4'b0000};
    vecs[12] = '{16'hF0FC, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 4'b0000};
    vecs[13] = '{16'hF00C, 4'b0011, 32'hABCD_0004, 1'b1, 32'h0000_0001, 4'b0000};
    vecs[14] = '{16'hF01C, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0004, 4'b0000};
    vecs[15] = '{16'hEC00, 4'b0000, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0000};
    vecs[16] = '{16'hFFF4, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_000A, 4'b0000};

    rst = 1'b0;
    do_reset();

    // Reset state of the serial outputs.
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    step();

    // Register/pass-through table.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].addr, vecs[i].wen, vecs[i].wdata);
      @(negedge clk);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), dm_read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_sram_wen", i), {28'd0, sram_w_en}, {28'd0, vecs[i].exp_swen});
      step();
    end

    // One 8N1 frame of 0x55 at div=4.
    do_reset();
    data = 8'h55;
    drive(16'hF00C, 4'b0011, 32'd4); step();
    drive(16'hF000, 4'b0001, {24'd0, data}); step();
    @(negedge clk);
    check("frame_pre_tx", {31'd0, tx}, 32'd1);
    check("frame_pre_busy", {31'd0, tx_busy}, 32'd1);
    step();
    for (int k = 0; k < 40; k++) begin
      bi = k / 4;
      if (bi == 0)      exp_bit = 1'b0;
      else if (bi == 9) exp_bit = 1'b1;
      else              exp_bit = data[bi-1];
      @(negedge clk);
      check($sformatf("frame_tx_c%0d", k), {31'd0, tx}, {31'd0, exp_bit});
      check($sformatf("frame_busy_c%0d", k), {31'd0, tx_busy}, 32'd1);
      step();
    end
    @(negedge clk);
    check("frame_end_tx", {31'd0, tx}, 32'd1);
    check("frame_end_busy", {31'd0, tx_busy}, 32'd0);
    step();

    // Overflow: 10 back-to-back pushes at div=100.
    do_reset();
    drive(16'hF00C, 4'b0011, 32'd100); step();
    for (int i = 0; i < 10; i++) begin
      drive(16'hF000, 4'b0001, 32'h30 + i);
      step();
    end
    drive(16'hF004, 4'b0000, 32'h0); @(negedge clk);
    check("ovf_status", dm_read_data, 32'h0000_000D); step();
    drive(16'hF004, 4'b0001, 32'h0); @(negedge clk);
    check("ovf_wr0_cycle", dm_read_data, 32'h0000_000D); step();
    drive(16'hF004, 4'b0000, 32'h0); @(negedge clk);
    check("ovf_after_wr0", dm_read_data, 32'h0000_000D); step();
    drive(16'hF004, 4'b0001, 32'h1); step();
    drive(16'hF004, 4'b0000, 32'h0); @(negedge clk);
    check("ovf_cleared", dm_read_data, 32'h0000_000C); step();

    // Cycle counter.
    do_reset();
    drive(16'hF008, 4'b1111, 32'hFFFF_FFFE); step();
`ifdef MMIO_CYCLE_CNT_EN
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_written", dm_read_data, 32'hFFFF_FFFE); step();
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_plus1", dm_read_data, 32'hFFFF_FFFF); step();
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_wrap", dm_read_data, 32'h0000_0000);
    halt = 1'b1;
    step(); step();
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_halt_hold", dm_read_data, 32'h0000_0000);
    halt = 1'b0;
    step();
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_resume", dm_read_data, 32'h0000_0001); step();
`else
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_absent_rd0", dm_read_data, 32'h0000_0000); step();
    step();
    drive(16'hF008, 4'b0000, 32'h0); @(negedge clk);
    check("cyc_absent_rd1", dm_read_data, 32'h0000_0000); step();
`endif

    // Reset asserted mid-frame with a second byte queued.
    do_reset();
    drive(16'hF00C, 4'b0011, 32'd4); step();
    drive(16'hF000, 4'b0001, 32'h0000_00A5); step();
    drive(16'hF000, 4'b0001, 32'h0000_003C); step();
    @(negedge clk);
    check("midrst_start_bit", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_tx_async", {31'd0, tx}, 32'd1);
    check("midrst_busy_async", {31'd0, tx_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(16'hF004, 4'b0000, 32'h0); @(negedge clk);
    check("midrst_status", dm_read_data, 32'h0000_0002); step();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("midrst_idle_tx_c%0d", k), {31'd0, tx}, 32'd1);
      step();
    end
    drive(16'hF00C, 4'b0000, 32'h0); @(negedge clk);
    check("midrst_div", dm_read_data, 32'h0000_01B2); step();
    drive(16'hF004, 4'b0000, 32'h0); @(negedge clk);
    check("midrst_status_late", dm_read_data, 32'h0000_0002); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_bridge.md
# mmio_uart_bridge

Data-memory-side bridge between the pipeline core's data port (`dm_addr`/`dm_w_en`/`dm_write_data`/`dm_read_data`) and the data SRAM.
- Decodes a memory-mapped I/O window at 0xF000–0xFFFF.
- Passes all other accesses straight through to the SRAM.
- Inside the window it provides a byte-wide TX FIFO drained by an 8N1 serial transmitter, a status register, a programmable baud divisor and a free-running cycle counter.
- Lets test programs print characters and measure run time without a testbench-side memory monitor.

## Interface
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..64
- `DEFAULT_DIV`, 16'd434, baud divisor loaded at reset (clock cycles per serial bit)
- `clk` in 1: core clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `dm_addr` in 16: byte address from the core's E/M register.
- `dm_w_en` in 4: per-byte write enables from the core.
- `dm_write_data` in 32: store data from the core.
- `dm_read_data` out 32: load data to the core, combinational in the same cycle as `dm_addr`.
- `halt` in 1: core halt flag; freezes the cycle counter.
- `sram_addr` out 16: equals `dm_addr`.
- `sram_w_en` out 4: equals `dm_w_en` outside the window, 4'b0000 inside it.
- `sram_write_data` out 32: equals `dm_write_data`.
- `sram_read_data` in 32: SRAM read data.
- `tx` out 1: serial output, idle high.
- `tx_busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- Window select: `mmio = (dm_addr[15:12] == 4'hF)`. Register index is `dm_addr[3:2]`; `dm_addr[11:4]` is ignored, so registers alias every 16 bytes.
- Read mux: `dm_read_data = mmio ? reg_value : sram_read_data`.
- 0x0 TXDATA
  - Write with `dm_w_en[0]` pushes `dm_write_data[7:0]`.
  - Reads return 0.
- 0x4 STATUS
  - Read returns {28'b0, `tx_busy`, full, empty, overflow}.
  - Write with `dm_w_en[0]` and `dm_write_data[0]`=1 clears overflow.
- 0x8 CYCLE
  - 32-bit counter; increments every cycle while `halt`=0 and wraps 0xFFFFFFFF→0.
  - Writes only when `dm_w_en`=4'b1111; the written value replaces that cycle's increment.
- 0xC BAUD_DIV
  - Read returns {16'b0, div}.
  - Write with `dm_w_en[1:0]`=2'b11 loads `dm_write_data[15:0]`. A written value of 0 is stored as 1.
- FIFO
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; full/empty derived from the pointer MSB.
  - Push while full is dropped and sets sticky overflow, except when a pop occurs in the same cycle; then the push is accepted.
  - Overflow set and clear in the same cycle: set wins.
- Transmitter FSM
  - IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for div cycles, then DATA.
  - DATA: 8 bits LSB first, div cycles each, then STOP.
  - STOP: `tx`=1 for div cycles, then IDLE.
  - The bit counter reloads from the current div at each bit boundary, so a mid-frame divisor change applies from the next bit.

## Timing
- Reset values:
  - `tx`=1, `tx_busy`=0.
  - FIFO empty, overflow=0, CYCLE=0, div=DEFAULT_DIV, FSM=IDLE.
  - `dm_read_data` follows the combinational mux.
- Register writes, pushes and pops take effect at the rising edge ending the access cycle. A load in the following cycle sees the new value.
- Push at edge N into an empty FIFO with FSM idle:
  - pop at edge N+1;
  - `tx` falls after edge N+1;
  - the frame occupies 10·div cycles;
  - the next frame's start bit begins the cycle after the stop bit ends, if data is queued.
- `tx_busy` is registered and reflects state after each edge.
- Reset asserted mid-frame: `tx` returns to 1 immediately and FIFO contents are discarded.

## Configuration
- `MMIO_CYCLE_CNT_EN` defined: CYCLE register is implemented as above.
- Not defined: no counter flops; CYCLE reads 0 and writes are ignored.

## Test plan
- After reset: STATUS reads 0x2; BAUD_DIV reads 434; SRAM write to 0x0100 with w_en 4'b1111 reaches the SRAM unchanged.
- Store 0xF000 w_en 4'b1111 to 0xF000 → `sram_w_en`=0; SRAM contents unchanged.
- div=4, push 0x55:
  - `tx` falls one cycle after the push edge;
  - `tx` then shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles;
  - `tx_busy` drops after 40 cycles.
- div=100, push 10 bytes back-to-back (FIFO_DEPTH 8):
  - first byte popped, 8 queued, last byte dropped;
  - overflow=1;
  - writing 1 to STATUS clears it.
- With the macro defined: write CYCLE=0xFFFFFFFE, read two cycles later → 0x00000000. Assert `halt` → value holds.
- Assert `rst` low mid-frame → `tx`=1 immediately, STATUS=0x2 after release.
